// File: rtl/decode_pkg.sv
// Shared definitions for the decode-to-operand stage: opcodes, immediate format codes
// and the decoded bundle carried to the operand-B mux.
package decode_pkg;

    localparam int XLEN  = 32;
    localparam int IMM_W = 25;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // IMM_LOAD doubles as the plain I-type sign-extended format used by ALU ops.
    typedef enum logic [2:0] {
        IMM_LOAD   = 3'b000,
        IMM_LOADU  = 3'b001,
        IMM_STORE  = 3'b010,
        IMM_BRANCH = 3'b100,
        IMM_JALR   = 3'b101,
        IMM_NONE   = 3'b111
    } imm_sample_e;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [IMM_W-1:0] imm;
        imm_sample_e      immSample;
        logic             d;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic             illegal;
    } dec_bundle_t;

endpackage

// File: rtl/instr_classify.sv
// Purely combinational opcode/funct3 classifier: immediate format, operand-B select
// and the unsupported-opcode flag.
module instr_classify
    import decode_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    output imm_sample_e imm_sample,
    output logic        use_rs2,
    output logic        illegal
);

    always_comb begin
        imm_sample = IMM_NONE;
        use_rs2    = 1'b0;
        illegal    = 1'b0;
        case (opcode)
            OP_R: begin
                imm_sample = IMM_LOAD;
                use_rs2    = 1'b1;
            end
            OP_I:      imm_sample = IMM_LOAD;
            // LBU and LHU need a zero-extending sampler downstream.
            OP_LOAD:   imm_sample = (funct3 == 3'b100 || funct3 == 3'b101) ? IMM_LOADU : IMM_LOAD;
            OP_STORE:  imm_sample = IMM_STORE;
            OP_BRANCH: imm_sample = IMM_BRANCH;
            OP_JALR:   imm_sample = IMM_JALR;
            default:   illegal    = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_operand_stage.sv
// Decode-to-operand pipeline stage with a valid/ready handshake on both sides.
// Define DECODE_SKID_EN to add a skid entry and fully registered in_ready.
module decode_operand_stage
    import decode_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [IMM_W-1:0] out_imm,
    output logic [2:0]       out_immSample,
    output logic             out_D,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic             out_illegal
);

    imm_sample_e cls_sample;
    logic        cls_use_rs2;
    logic        cls_illegal;
    dec_bundle_t new_bundle;
    dec_bundle_t out_q;
    logic        out_vld_q;
    logic        accept;

    instr_classify u_classify (
        .opcode     (in_instr[6:0]),
        .funct3     (in_instr[14:12]),
        .imm_sample (cls_sample),
        .use_rs2    (cls_use_rs2),
        .illegal    (cls_illegal)
    );

    always_comb begin
        new_bundle.pc        = in_pc;
        new_bundle.imm       = in_instr[31:7];
        new_bundle.immSample = cls_sample;
        new_bundle.d         = cls_use_rs2;
        new_bundle.rs1       = in_instr[19:15];
        new_bundle.rs2       = in_instr[24:20];
        new_bundle.rd        = in_instr[11:7];
        new_bundle.illegal   = cls_illegal;
    end

    assign accept = in_valid && in_ready;

`ifdef DECODE_SKID_EN
    dec_bundle_t skid_q;
    logic        skid_vld_q;
    logic        slot_free;

    assign in_ready  = !skid_vld_q;
    assign slot_free = !out_vld_q || out_ready;

    // Skid content is always older than anything at the input, since in_ready
    // stays low while it is occupied; it therefore drains first.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else if (flush) begin
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
        end else if (slot_free) begin
            if (skid_vld_q) begin
                out_q      <= skid_q;
                out_vld_q  <= 1'b1;
                skid_vld_q <= 1'b0;
            end else if (accept) begin
                out_q     <= new_bundle;
                out_vld_q <= 1'b1;
            end else begin
                out_vld_q <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= new_bundle;
            skid_vld_q <= 1'b1;
        end
    end
`else
    assign in_ready = !out_vld_q || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else if (flush) begin
            out_vld_q <= 1'b0;
        end else if (accept) begin
            out_q     <= new_bundle;
            out_vld_q <= 1'b1;
        end else if (out_ready) begin
            out_vld_q <= 1'b0;
        end
    end
`endif

    assign out_valid     = out_vld_q;
    assign out_pc        = out_q.pc;
    assign out_imm       = out_q.imm;
    assign out_immSample = out_q.immSample;
    assign out_D         = out_q.d;
    assign out_rs1       = out_q.rs1;
    assign out_rs2       = out_q.rs2;
    assign out_rd        = out_q.rd;
    assign out_illegal   = out_q.illegal;

endmodule
